pwm_multi: RTL and testbench

Parametrised multi-channel PWM generator on the CPLD's 8-bit CSR bus, replacing per-channel single PWM instances. Provides NUM_CHANNELS independent channels, each with its own enable, period mode and double-buffered duty cycle, all clocked from the shared slow tick (pwm_ce). The enable outputs let the top level multiplex channels onto pins otherwise owned by GPIO. csr_do is OR-combined with the other CSR slaves.

---
 rtl/pwm_multi.sv | 137 +++++++++++++
 tb/tb_pwm_multi.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator on the 8-bit CSR bus.
// Channel i: CTRL at BASE_ADDR+2i, CYCLE at BASE_ADDR+2i+1.
// Optional feature macro: PWM_POLARITY_EN (adds CTRL.POL output inversion).
module pwm_multi #(
  parameter logic [4:0] BASE_ADDR    = 5'h0c,
  parameter int         NUM_CHANNELS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pwm_ce,
  input  logic [4:0]              csr_a,
  input  logic [7:0]              csr_di,
  input  logic                    csr_we,
  output logic [7:0]              csr_do,
  output logic [NUM_CHANNELS-1:0] pwm_en,
  output logic [NUM_CHANNELS-1:0] pwm_out
);

  // Per-channel readback words gathered for the shared read mux.
  logic [7:0] ctrl_rd  [NUM_CHANNELS];
  logic [7:0] cycle_rd [NUM_CHANNELS];

`ifdef PWM_POLARITY_EN
  logic unused_di;
  assign unused_di = ^csr_di[5:2];
`else
  logic unused_di;
  assign unused_di = ^csr_di[6:2];
`endif

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      // Addresses are compared in 6 bits so BASE_ADDR+2*NUM_CHANNELS == 32 cannot alias.
      localparam logic [5:0] CTRL_ADDR  = 6'(BASE_ADDR) + 6'(2 * gi);
      localparam logic [5:0] CYCLE_ADDR = CTRL_ADDR + 6'd1;

      logic       ctrl_wr, cycle_wr;
      logic       en_reg, en_next;
      logic [1:0] mode_reg, mode_next;
      logic [7:0] pending_reg, pending_next;
      logic [7:0] duty_reg, duty_next;
      logic [6:0] cnt_reg, cnt_next;
      logic [6:0] period_last;
      logic       wrap;
      logic       raw_next;
      logic       out_reg, out_next;
      logic       pol_bit;

      assign ctrl_wr     = csr_we && ({1'b0, csr_a} == CTRL_ADDR);
      assign cycle_wr    = csr_we && ({1'b0, csr_a} == CYCLE_ADDR);
      assign period_last = 7'h7f >> mode_reg;
      // Wrap is judged on the pre-write CTRL so a coincident write cannot retime this step.
      assign wrap        = en_reg && pwm_ce && (cnt_reg == period_last);

`ifdef PWM_POLARITY_EN
      logic pol_reg;
      // Output polarity bit, written with the rest of CTRL.
      always_ff @(posedge clk) begin
        if (rst)          pol_reg <= 1'b0;
        else if (ctrl_wr) pol_reg <= csr_di[6];
      end
      // Output sees the polarity as it will be after this edge.
      assign pol_bit = ctrl_wr ? csr_di[6] : pol_reg;
      assign ctrl_rd[gi] = {en_reg, pol_reg, 4'b0000, mode_reg};
`else
      assign pol_bit = 1'b0;
      assign ctrl_rd[gi] = {en_reg, 1'b0, 4'b0000, mode_reg};
`endif
      assign cycle_rd[gi] = pending_reg;

      // Next-state: CSR writes, counter step, double-buffered duty load, output level.
      always_comb begin
        en_next      = en_reg;
        mode_next    = mode_reg;
        pending_next = pending_reg;
        duty_next    = duty_reg;
        cnt_next     = cnt_reg;
        raw_next     = 1'b0;
        out_next     = 1'b0;

        if (cycle_wr) pending_next = csr_di;
        if (ctrl_wr) begin
          en_next   = csr_di[7];
          mode_next = csr_di[1:0];
        end

        // Duty follows pending while idle; when running it reloads only at wrap,
        // taking a same-cycle CYCLE write through the bypass.
        if (!en_reg || wrap) duty_next = pending_next;

        if (!en_reg)      cnt_next = 7'd0;
        else if (wrap)    cnt_next = 7'd0;
        else if (pwm_ce)  cnt_next = cnt_reg + 7'd1;

        // A change of EN or MODE restarts the period and overrides the step.
        if ((en_next != en_reg) || (mode_next != mode_reg)) cnt_next = 7'd0;

        raw_next = en_next && ({1'b0, cnt_next} < duty_next);
        out_next = en_next ? (raw_next ^ pol_bit) : pol_bit;
      end

      // Channel state registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          en_reg      <= 1'b0;
          mode_reg    <= 2'd0;
          pending_reg <= 8'h00;
          duty_reg    <= 8'h00;
          cnt_reg     <= 7'd0;
          out_reg     <= 1'b0;
        end else begin
          en_reg      <= en_next;
          mode_reg    <= mode_next;
          pending_reg <= pending_next;
          duty_reg    <= duty_next;
          cnt_reg     <= cnt_next;
          out_reg     <= out_next;
        end
      end

      assign pwm_en[gi]  = en_reg;
      assign pwm_out[gi] = out_reg;
    end
  endgenerate

  // Combinational read mux; zero outside the block so it can be OR-combined.
  always_comb begin
    csr_do = 8'h00;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if ({1'b0, csr_a} == (6'(BASE_ADDR) + 6'(2 * i)))
        csr_do = ctrl_rd[i];
      else if ({1'b0, csr_a} == (6'(BASE_ADDR) + 6'(2 * i) + 6'd1))
        csr_do = cycle_rd[i];
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed + randomized stimulus against a behavioural channel model.
module tb_pwm_multi;
  localparam logic [4:0] BASE = 5'h0c;
  localparam int         NCH  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           pwm_ce = 1'b0;
  logic [4:0]     csr_a = 5'd0;
  logic [7:0]     csr_di = 8'h00;
  logic           csr_we = 1'b0;
  logic [7:0]     csr_do;
  logic [NCH-1:0] pwm_en;
  logic [NCH-1:0] pwm_out;

  pwm_multi #(.BASE_ADDR(BASE), .NUM_CHANNELS(NCH)) dut (
    .clk(clk), .rst(rst), .pwm_ce(pwm_ce), .csr_a(csr_a), .csr_di(csr_di),
    .csr_we(csr_we), .csr_do(csr_do), .pwm_en(pwm_en), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ce_div = 4;
  int cyc = 0;
  int high0 = 0;

  // Behavioural model state, one entry per channel.
  int m_en[NCH], m_mode[NCH], m_pol[NCH], m_pend[NCH], m_duty[NCH], m_cnt[NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_read(input int a);
    for (int i = 0; i < NCH; i++) begin
      if (a == int'(BASE) + 2 * i)     return (m_en[i] << 7) | (m_pol[i] << 6) | m_mode[i];
      if (a == int'(BASE) + 2 * i + 1) return m_pend[i];
    end
    return 0;
  endfunction

  function automatic int model_out(input int i);
    if (m_en[i] != 0) return ((m_cnt[i] < m_duty[i]) ? 1 : 0) ^ m_pol[i];
    return m_pol[i];
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        m_en[i] = 0; m_mode[i] = 0; m_pol[i] = 0;
        m_pend[i] = 0; m_duty[i] = 0; m_cnt[i] = 0;
      end else begin
        int period;
        bit ctrl_hit, cyc_hit, wrapping;
        int new_en, new_mode;
        period   = 128 >> m_mode[i];
        ctrl_hit = csr_we && (int'(csr_a) == int'(BASE) + 2 * i);
        cyc_hit  = csr_we && (int'(csr_a) == int'(BASE) + 2 * i + 1);
        wrapping = (m_en[i] != 0) && pwm_ce && (m_cnt[i] == period - 1);
        if (cyc_hit) m_pend[i] = int'(csr_di);
        if (m_en[i] == 0 || wrapping) m_duty[i] = m_pend[i];
        if (m_en[i] == 0) m_cnt[i] = 0;
        else if (pwm_ce) m_cnt[i] = (m_cnt[i] + 1) % period;
        if (ctrl_hit) begin
          new_en   = int'(csr_di[7]);
          new_mode = int'(csr_di[1:0]);
          if (new_en != m_en[i] || new_mode != m_mode[i]) m_cnt[i] = 0;
          m_en[i]   = new_en;
          m_mode[i] = new_mode;
`ifdef PWM_POLARITY_EN
          m_pol[i]  = int'(csr_di[6]);
`endif
        end
      end
    end
  endtask

  // One clock: check the read mux, clock the DUT and the model, check outputs.
  task automatic tick();
    if (ce_div > 0) pwm_ce = ((cyc % ce_div) == 0);
    else            pwm_ce = ($urandom_range(3) == 0);
    #1;
    check("csr_do", {24'd0, csr_do}, model_read(int'(csr_a)));
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("pwm_out%0d", i), {31'd0, pwm_out[i]}, model_out(i));
      check($sformatf("pwm_en%0d", i), {31'd0, pwm_en[i]}, m_en[i]);
    end
    if (pwm_out[0]) high0++;
    csr_we = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input int a, input int d);
    csr_a  = 5'(a);
    csr_di = 8'(d);
    csr_we = 1'b1;
    $display("wr a=%02h d=%02h t=%0t", a, d, $time);
    tick();
  endtask

  task automatic rd_check(input string tag, input int a, input int exp);
    csr_a = 5'(a);
    #1;
    check(tag, {24'd0, csr_do}, exp);
    tick();
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_en[i] = 0; m_mode[i] = 0; m_pol[i] = 0;
      m_pend[i] = 0; m_duty[i] = 0; m_cnt[i] = 0;
    end

    // Reset state and read map.
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    check("rst_pwm_out", {30'd0, pwm_out}, 0);
    check("rst_pwm_en", {30'd0, pwm_en}, 0);
    for (int a = int'(BASE) - 1; a <= int'(BASE) + 2 * NCH; a++)
      rd_check("rst_rd", a, 0);

    // Ch0 period 16, duty 4, tick every 4 clk: 16 high clocks per 64.
    wr(BASE + 1, 8'h04);
    wr(BASE, 8'h83);
    run(64);
    high0 = 0; run(128);
    check("duty4_high", high0, 32);
    wr(BASE + 1, 8'h10);
    run(128);
    high0 = 0; run(128);
    check("duty_full_high", high0, 128);
    wr(BASE + 1, 8'h00);
    run(128);
    high0 = 0; run(128);
    check("duty_zero_high", high0, 0);

    // Ch1 mode 0, duty change mid-period, then a write on the wrap cycle.
    wr(BASE + 3, 8'h20);
    wr(BASE + 2, 8'h80);
    run(200);
    wr(BASE + 3, 8'h60);
    run(1100);
    begin
      bit found = 1'b0;
      for (int k = 0; k < 1200 && !found; k++) begin
        if (m_en[1] != 0 && m_cnt[1] == 127 && (cyc % ce_div) == 0) found = 1'b1;
        else tick();
      end
      check("wrap_found", found, 1);
      wr(BASE + 3, 8'h30);
      run(600);
    end

    // Ch0 mode 3 -> 1 mid-period while ch1 keeps running.
    wr(BASE + 1, 8'h08);
    wr(BASE, 8'h83);
    run(30);
    wr(BASE, 8'h81);
    run(300);

`ifdef PWM_POLARITY_EN
    wr(BASE, 8'h40);
    run(2);
    check("pol_idle", {31'd0, pwm_out[0]}, 1);
    wr(BASE + 1, 8'h04);
    wr(BASE, 8'hC3);
    run(200);
    rd_check("pol_rd", BASE, 8'hC3);
`else
    wr(BASE, 8'hC3);
    rd_check("nopol_rd", BASE, 8'h83);
`endif

    // Reset mid-period, then restart.
    run(37);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_out", {30'd0, pwm_out}, 0);
    check("mid_rst_en", {30'd0, pwm_en}, 0);
    rd_check("mid_rst_rd", BASE + 1, 0);
    wr(BASE + 1, 8'h05);
    wr(BASE, 8'h82);
    run(100);

    // Randomized traffic: random ticks, writes across and around the map, rare resets.
    ce_div = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(699) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else if ($urandom_range(7) == 0) begin
        int a, d;
        a = int'(BASE) - 1 + int'($urandom_range(2 * NCH + 1));
        d = int'($urandom_range(255));
        if ($urandom_range(3) != 0) d = d | 8'h80;
        wr(a, d);
      end else begin
        csr_a = 5'(int'(BASE) - 1 + int'($urandom_range(2 * NCH + 1)));
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
